// File: rtl/stock_draw_ctrl.sv
// ---------------------------------------------------------------------------
// stock_draw_ctrl
//   Owns the talon (draw pile) and face-up waste pile after the deal stage.
//   Loads both piles from the dealt buses, then serves draw / take / recycle
//   requests. Each pile is a LIFO held in a register array; the top index is
//   the pile count minus one.
//
//   Optional build macro: RECYCLE_LIMIT_EN
//     defined   -> recycle passes limited to MAX_RECYCLES (a pass counter is built)
//     undefined -> unlimited recycles, no pass counter
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   load_valid          pulse: latch load_talon/load_waste and (re)start LOAD
//   load_talon          TALON_DEPTH card words, slot 0 = bottom
//   load_waste          WASTE_INIT card words, slot 0 = bottom
//   draw_req            draw one card, or recycle when the talon is empty
//   take_req            remove the top waste card
//   ack_draw, ack_take  registered one-cycle completion pulses
//   err                 registered one-cycle refusal pulse
//   busy, ready         busy in LOAD/RECYCLE, ready in READY
//   waste_top           top waste card (0 when the waste is empty)
//   talon_count         cards in the talon
//   waste_count         cards in the waste
//
// Card word: [6:3] rank, [2:1] suit, [0] face-up; all-zero = empty slot.
//
// state    | meaning
// S_IDLE   | after reset, waiting for the first load
// S_LOAD   | scanning latched slots into the piles, one per cycle
// S_READY  | serving draw / take requests
// S_RECYCLE| moving waste cards back onto the talon, one per cycle
// ---------------------------------------------------------------------------
module stock_draw_ctrl #(
  parameter int CARD_SIZE    = 7,
  parameter int TALON_DEPTH  = 24,
  parameter int WASTE_INIT   = 3,
  parameter int MAX_RECYCLES = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_valid,
  input  logic [TALON_DEPTH*CARD_SIZE-1:0]  load_talon,
  input  logic [WASTE_INIT*CARD_SIZE-1:0]   load_waste,
  input  logic                              draw_req,
  input  logic                              take_req,
  output logic                              ack_draw,
  output logic                              ack_take,
  output logic                              err,
  output logic                              busy,
  output logic                              ready,
  output logic [CARD_SIZE-1:0]              waste_top,
  output logic [4:0]                        talon_count,
  output logic [4:0]                        waste_count
);

  localparam int         DEPTH       = TALON_DEPTH + WASTE_INIT;
  localparam logic [4:0] SCAN_LAST   = 5'(DEPTH - 1);
  localparam logic [4:0] TALON_SLOTS = 5'(TALON_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_RECYCLE} state_t;

  state_t               state;
  logic [CARD_SIZE-1:0] talon_mem [DEPTH];
  logic [CARD_SIZE-1:0] waste_mem [DEPTH];
  logic [CARD_SIZE-1:0] scan_buf  [DEPTH];
  logic [4:0]           scan_idx;

  logic [CARD_SIZE-1:0] scan_card;
  logic [CARD_SIZE-1:0] talon_top;
  logic [CARD_SIZE-1:0] waste_below;
  logic                 recycle_blocked;

`ifdef RECYCLE_LIMIT_EN
  logic [3:0] pass_cnt;
  assign recycle_blocked = (pass_cnt == 4'(MAX_RECYCLES));
`else
  assign recycle_blocked = 1'b0;
`endif

  function automatic logic [CARD_SIZE-1:0] face_up(input logic [CARD_SIZE-1:0] c);
    return {c[CARD_SIZE-1:1], 1'b1};
  endfunction

  function automatic logic [CARD_SIZE-1:0] face_down(input logic [CARD_SIZE-1:0] c);
    return {c[CARD_SIZE-1:1], 1'b0};
  endfunction

  // waste_top always mirrors waste_mem[waste_count-1]; waste_below is the
  // card that becomes the top after a waste pop.
  always_comb begin
    scan_card   = scan_buf[scan_idx];
    talon_top   = '0;
    waste_below = '0;
    if (talon_count != 5'd0) talon_top = talon_mem[talon_count - 5'd1];
    if (waste_count > 5'd1)  waste_below = waste_mem[waste_count - 5'd2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ack_draw    <= 1'b0;
      ack_take    <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      waste_top   <= '0;
      talon_count <= '0;
      waste_count <= '0;
      scan_idx    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        talon_mem[i] <= '0;
        waste_mem[i] <= '0;
        scan_buf[i]  <= '0;
      end
`ifdef RECYCLE_LIMIT_EN
      pass_cnt    <= '0;
`endif
    end else begin
      ack_draw <= 1'b0;
      ack_take <= 1'b0;
      err      <= 1'b0;

      if (load_valid) begin
        // Restart from any state; requests in this cycle are dropped.
        state       <= S_LOAD;
        busy        <= 1'b1;
        ready       <= 1'b0;
        scan_idx    <= '0;
        talon_count <= '0;
        waste_count <= '0;
        waste_top   <= '0;
        for (int i = 0; i < TALON_DEPTH; i++)
          scan_buf[i] <= load_talon[i*CARD_SIZE +: CARD_SIZE];
        for (int i = 0; i < WASTE_INIT; i++)
          scan_buf[TALON_DEPTH+i] <= load_waste[i*CARD_SIZE +: CARD_SIZE];
        for (int i = 0; i < DEPTH; i++) begin
          talon_mem[i] <= '0;
          waste_mem[i] <= '0;
        end
`ifdef RECYCLE_LIMIT_EN
        pass_cnt    <= '0;
`endif
      end else begin
        case (state)
          S_LOAD: begin
            if (scan_card != '0) begin
              if (scan_idx < TALON_SLOTS) begin
                talon_mem[talon_count] <= face_down(scan_card);
                talon_count            <= talon_count + 5'd1;
              end else begin
                waste_mem[waste_count] <= face_up(scan_card);
                waste_count            <= waste_count + 5'd1;
                waste_top              <= face_up(scan_card);
              end
            end
            if (scan_idx == SCAN_LAST) begin
              state <= S_READY;
              busy  <= 1'b0;
              ready <= 1'b1;
            end else begin
              scan_idx <= scan_idx + 5'd1;
            end
          end

          S_READY: begin
            if (take_req) begin
              // A simultaneous draw_req is dropped.
              if (waste_count != 5'd0) begin
                waste_mem[waste_count - 5'd1] <= '0;
                waste_count                   <= waste_count - 5'd1;
                waste_top                     <= waste_below;
                ack_take                      <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else if (draw_req) begin
              if (talon_count != 5'd0) begin
                talon_mem[talon_count - 5'd1] <= '0;
                talon_count                   <= talon_count - 5'd1;
                waste_mem[waste_count]        <= face_up(talon_top);
                waste_count                   <= waste_count + 5'd1;
                waste_top                     <= face_up(talon_top);
                ack_draw                      <= 1'b1;
              end else if (waste_count != 5'd0) begin
                if (recycle_blocked) begin
                  err <= 1'b1;
                end else begin
                  state <= S_RECYCLE;
                  busy  <= 1'b1;
                  ready <= 1'b0;
`ifdef RECYCLE_LIMIT_EN
                  pass_cnt <= pass_cnt + 4'd1;
`endif
                end
              end else begin
                err <= 1'b1;
              end
            end
          end

          S_RECYCLE: begin
            // Waste top goes to talon top, so the old waste bottom ends on top.
            talon_mem[talon_count]        <= face_down(waste_top);
            talon_count                   <= talon_count + 5'd1;
            waste_mem[waste_count - 5'd1] <= '0;
            waste_count                   <= waste_count - 5'd1;
            waste_top                     <= waste_below;
            if (waste_count == 5'd1) begin
              state    <= S_READY;
              busy     <= 1'b0;
              ready    <= 1'b1;
              ack_draw <= 1'b1;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
